// File: rtl/dispatch_pkg.sv
// Shared types and sizes for the dispatch stage: the renamed-instruction
// record that travels from rename through dispatch into the stations.
package dispatch_pkg;

  localparam int NUM_PREG  = 128;
  localparam int PREG_W    = 7;
  localparam int ROB_TAG_W = 6;

  // Functional-unit selector carried in the instruction; 2'b11 behaves as ALU.
  typedef enum logic [1:0] {
    FU_ALU  = 2'b00,
    FU_BR   = 2'b01,
    FU_LSU  = 2'b10,
    FU_RSVD = 2'b11
  } fu_e;

  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  typedef struct packed {
    logic [31:0]          pc;
    logic [ROB_TAG_W-1:0] rob_tag;
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [6:0]           func7;
    logic [1:0]           fu;
    logic [PREG_W-1:0]    pd_new;
    logic [PREG_W-1:0]    ps1;
    logic [PREG_W-1:0]    ps2;
    logic [31:0]          imm;
  } rename_data;

endpackage

// File: rtl/dispatch_unit_if.sv
// Bundle of every dispatch-stage signal except clock and reset.
// slave  : the dispatch unit itself.
// master : the surrounding pipeline (rename, ROB, stations, CDB).
interface dispatch_unit_if;

  logic                                       rename_valid;
  dispatch_pkg::rename_data                   r_data;
  logic                                       dispatch_ready;
  logic                                       rob_full;
  logic                                       rob_alloc;
  logic                                       rs_full_alu;
  logic                                       rs_full_br;
  logic                                       rs_full_lsu;
  logic                                       di_en_alu;
  logic                                       di_en_br;
  logic                                       di_en_lsu;
  dispatch_pkg::rename_data                   d_data;
  logic                                       cdb_valid;
  logic [dispatch_pkg::PREG_W-1:0]            cdb_pd;
  logic                                       mispredict;
  logic [dispatch_pkg::NUM_PREG-1:0]          preg_rtable;

  modport slave (
    input  rename_valid, r_data, rob_full,
    input  rs_full_alu, rs_full_br, rs_full_lsu,
    input  cdb_valid, cdb_pd, mispredict,
    output dispatch_ready, rob_alloc,
    output di_en_alu, di_en_br, di_en_lsu,
    output d_data, preg_rtable
  );

  modport master (
    output rename_valid, r_data, rob_full,
    output rs_full_alu, rs_full_br, rs_full_lsu,
    output cdb_valid, cdb_pd, mispredict,
    input  dispatch_ready, rob_alloc,
    input  di_en_alu, di_en_br, di_en_lsu,
    input  d_data, preg_rtable
  );

endinterface

// File: rtl/dispatch_unit.sv
// Dispatch stage: one-entry holding register between rename and the
// ALU/branch/LSU reservation stations, ROB allocation strobe, and the
// physical-register ready table used by the stations for wakeup.
module dispatch_unit
  import dispatch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  dispatch_unit_if.slave  bus
);

  logic                pend_valid_q, pend_valid_d;
  rename_data          pend_q, pend_d;
  logic [NUM_PREG-1:0] rtable_q, rtable_d;

  fu_e  fu_sel;
  logic sel_full;
  logic go;
  logic accept;
  logic ready;
  logic writes_rd;

  // Decode the target station of the held instruction and its full flag.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default infers a latch.
    fu_sel   = FU_ALU;
    sel_full = bus.rs_full_alu;
    unique case (pend_q.fu)
      2'b01: begin
        fu_sel   = FU_BR;
        sel_full = bus.rs_full_br;
      end
      2'b10: begin
        fu_sel   = FU_LSU;
        sel_full = bus.rs_full_lsu;
      end
      default: begin
        fu_sel   = FU_ALU;
        sel_full = bus.rs_full_alu;
      end
    endcase
  end

  // Handshake, strobes and next state of the holding register.
  always_comb begin
    go        = pend_valid_q && !bus.rob_full && !bus.mispredict && !sel_full;
    ready     = !bus.mispredict && (!pend_valid_q || go);
    accept    = bus.rename_valid && ready;
    writes_rd = (pend_q.opcode != OPC_STORE) && (pend_q.opcode != OPC_BRANCH) &&
                (pend_q.pd_new != '0);

    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    if (accept) begin
      pend_valid_d = 1'b1;
      pend_d       = bus.r_data;
    end else if (go || bus.mispredict) begin
      pend_valid_d = 1'b0;
    end
  end

  // Ready-table update: CDB sets, dispatch clears (clear wins), p0 always ready.
  always_comb begin
    rtable_d = rtable_q;
    if (bus.cdb_valid) begin
      rtable_d[bus.cdb_pd] = 1'b1;
    end
    if (go && writes_rd) begin
      rtable_d[pend_q.pd_new] = 1'b0;
    end
    rtable_d[0] = 1'b1;
  end

  // State registers: holding register and ready table.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      // NOTE: the ready table is a flop array, not a RAM, so it can and must
      // be reset: every register starts out ready.
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      rtable_q     <= '1;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      rtable_q     <= rtable_d;
    end
  end

  assign bus.dispatch_ready = ready;
  assign bus.rob_alloc      = go;
  assign bus.di_en_alu      = go && (fu_sel == FU_ALU);
  assign bus.di_en_br       = go && (fu_sel == FU_BR);
  assign bus.di_en_lsu      = go && (fu_sel == FU_LSU);
  assign bus.d_data         = pend_q;
  assign bus.preg_rtable    = rtable_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Testbench for dispatch_unit: directed scenarios plus a randomized phase.
// A negedge monitor keeps a queue-based scoreboard of instructions in flight
// and a ready-bit array, and compares every DUT output each cycle.
module tb_dispatch_unit;
  import dispatch_pkg::*;

  logic clk;
  logic reset;
  dispatch_unit_if bus();

  dispatch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int route(input logic [1:0] fu);
    if (fu == 2'b01) return 1;
    if (fu == 2'b10) return 2;
    return 0;
  endfunction

  function automatic rename_data mk(input logic [1:0] fu, input logic [6:0] op,
                                    input logic [6:0] pd);
    rename_data r;
    r.pc      = $urandom;
    r.rob_tag = 6'($urandom);
    r.opcode  = op;
    r.func3   = 3'($urandom);
    r.func7   = 7'($urandom);
    r.fu      = fu;
    r.pd_new  = pd;
    r.ps1     = 7'($urandom);
    r.ps2     = 7'($urandom);
    r.imm     = $urandom;
    return r;
  endfunction

  // ---------------- reference model + scoreboard (monitor) ----------------
  rename_data          sb[$];
  logic [NUM_PREG-1:0] m_rt = '1;
  rename_data          head;
  bit                  has, tgt_full, e_go, e_rdy;
  int                  tgt;

  // Compare each cycle with inputs stable, then advance the model for the edge.
  always @(negedge clk) begin
    if (mon_en) begin
      has      = (sb.size() > 0);
      head     = has ? sb[0] : '0;
      tgt      = route(head.fu);
      tgt_full = (tgt == 1) ? bus.rs_full_br : (tgt == 2) ? bus.rs_full_lsu : bus.rs_full_alu;
      e_go     = has && !bus.rob_full && !bus.mispredict && !tgt_full;
      e_rdy    = !bus.mispredict && (!has || e_go);

      check("mon_ready", bus.dispatch_ready, e_rdy);
      check("mon_rob_alloc", bus.rob_alloc, e_go);
      check("mon_di_en", {bus.di_en_alu, bus.di_en_br, bus.di_en_lsu},
            {e_go && tgt == 0, e_go && tgt == 1, e_go && tgt == 2});
      if (has) check("mon_d_data", bus.d_data, head);
      check("mon_rtable", bus.preg_rtable, m_rt);

      if (bus.cdb_valid) m_rt[bus.cdb_pd] = 1'b1;
      if (e_go) begin
        if (head.opcode != 7'h23 && head.opcode != 7'h63 && head.pd_new != 0)
          m_rt[head.pd_new] = 1'b0;
        void'(sb.pop_front());
      end
      m_rt[0] = 1'b1;
      if (bus.mispredict) sb.delete();
      if (bus.rename_valid && e_rdy) sb.push_back(bus.r_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rename_valid = 1'b0;
    bus.r_data       = '0;
    bus.rob_full     = 1'b0;
    bus.rs_full_alu  = 1'b0;
    bus.rs_full_br   = 1'b0;
    bus.rs_full_lsu  = 1'b0;
    bus.cdb_valid    = 1'b0;
    bus.cdb_pd       = '0;
    bus.mispredict   = 1'b0;
  endtask

  function automatic logic [2:0] strobes();
    return {bus.di_en_alu, bus.di_en_br, bus.di_en_lsu};
  endfunction

  rename_data d_ins, s_ins;
  logic [6:0] ops[5] = '{7'h33, 7'h13, 7'h23, 7'h63, 7'h03};

  initial begin
    reset = 1'b0;
    idle();

    // Reset state.
    repeat (2) @(posedge clk);
    #3;
    check("rst_d_data", bus.d_data, '0);
    check("rst_strobes", {strobes(), bus.rob_alloc}, 4'b0000);
    check("rst_rtable", bus.preg_rtable, {NUM_PREG{1'b1}});
    reset = 1'b1;
    #1;
    check("rst_ready", bus.dispatch_ready, 1'b1);
    cyc();
    mon_en = 1'b1;

    // Three instructions to ALU, branch, LSU on consecutive cycles.
    bus.rename_valid = 1'b1;
    bus.r_data = mk(2'b00, 7'h33, 7'd41);
    cyc();
    bus.r_data = mk(2'b01, 7'h63, 7'd3);
    @(negedge clk);
    check("seq_c1_strobes", strobes(), 3'b100);
    check("seq_c1_alloc", bus.rob_alloc, 1'b1);
    check("seq_c1_ready", bus.dispatch_ready, 1'b1);
    cyc();
    bus.r_data = mk(2'b10, 7'h03, 7'd12);
    @(negedge clk);
    check("seq_c2_strobes", strobes(), 3'b010);
    check("seq_c2_alloc", bus.rob_alloc, 1'b1);
    check("seq_c2_ready", bus.dispatch_ready, 1'b1);
    cyc();
    bus.rename_valid = 1'b0;
    @(negedge clk);
    check("seq_c3_strobes", strobes(), 3'b001);
    check("seq_c3_alloc", bus.rob_alloc, 1'b1);
    cyc();
    @(negedge clk);
    check("seq_idle_strobes", strobes(), 3'b000);
    check("seq_rt41_clear", bus.preg_rtable[41], 1'b0);

    // ALU station full for three cycles with pd_new 40.
    cyc();
    bus.rs_full_alu  = 1'b1;
    bus.rename_valid = 1'b1;
    d_ins = mk(2'b00, 7'h33, 7'd40);
    bus.r_data = d_ins;
    cyc();
    bus.rename_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ready", bus.dispatch_ready, 1'b0);
      check("stall_strobes", strobes(), 3'b000);
      check("stall_hold", bus.d_data, d_ins);
      cyc();
    end
    bus.rs_full_alu = 1'b0;
    @(negedge clk);
    check("stall_release", strobes(), 3'b100);
    cyc();
    @(negedge clk);
    check("stall_one_pulse", strobes(), 3'b000);
    check("stall_rt40_clear", bus.preg_rtable[40], 1'b0);

    // ROB full blocks dispatch until it drops.
    cyc();
    bus.rob_full     = 1'b1;
    bus.rename_valid = 1'b1;
    bus.r_data       = mk(2'b01, 7'h63, 7'd0);
    cyc();
    bus.rename_valid = 1'b0;
    @(negedge clk);
    check("robfull_alloc", bus.rob_alloc, 1'b0);
    check("robfull_strobes", strobes(), 3'b000);
    cyc();
    bus.rob_full = 1'b0;
    @(negedge clk);
    check("robfree_strobes", strobes(), 3'b010);
    check("robfree_alloc", bus.rob_alloc, 1'b1);

    // Same-edge dispatch clear and CDB set on 40; then CDB alone on 41.
    cyc();
    bus.cdb_valid    = 1'b1;
    bus.cdb_pd       = 7'd40;
    bus.rename_valid = 1'b1;
    bus.r_data       = mk(2'b00, 7'h33, 7'd40);
    cyc();
    bus.rename_valid = 1'b0;
    @(negedge clk);
    check("cdb_rt40_set", bus.preg_rtable[40], 1'b1);
    check("cdb_clash_strobe", strobes(), 3'b100);
    cyc();
    bus.cdb_pd = 7'd41;
    @(negedge clk);
    check("cdb_clash_clear_wins", bus.preg_rtable[40], 1'b0);
    check("cdb_rt41_before", bus.preg_rtable[41], 1'b0);
    cyc();
    bus.cdb_valid = 1'b0;
    @(negedge clk);
    check("cdb_rt41_set", bus.preg_rtable[41], 1'b1);

    // Store with pd_new 5, then an op writing p0.
    cyc();
    bus.rename_valid = 1'b1;
    bus.r_data = mk(2'b10, 7'h23, 7'd5);
    cyc();
    bus.r_data = mk(2'b00, 7'h13, 7'd0);
    @(negedge clk);
    check("store_to_lsu", strobes(), 3'b001);
    cyc();
    bus.rename_valid = 1'b0;
    @(negedge clk);
    check("p0_to_alu", strobes(), 3'b100);
    cyc();
    @(negedge clk);
    check("store_rt5_kept", bus.preg_rtable[5], 1'b1);
    check("p0_kept", bus.preg_rtable[0], 1'b1);

    // Mispredict while stalled drops the held instruction.
    cyc();
    bus.rs_full_br   = 1'b1;
    bus.rename_valid = 1'b1;
    bus.r_data       = mk(2'b01, 7'h63, 7'd0);
    cyc();
    bus.mispredict = 1'b1;
    bus.r_data     = mk(2'b00, 7'h33, 7'd50);
    @(negedge clk);
    check("mp_ready", bus.dispatch_ready, 1'b0);
    check("mp_strobes", strobes(), 3'b000);
    cyc();
    bus.mispredict   = 1'b0;
    bus.rename_valid = 1'b0;
    bus.rs_full_br   = 1'b0;
    @(negedge clk);
    check("mp_dropped", {strobes(), bus.rob_alloc}, 4'b0000);
    check("mp_rt50_kept", bus.preg_rtable[50], 1'b1);

    // Randomized traffic, checked by the monitor every cycle.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      bus.rename_valid = ($urandom_range(0, 9) < 7);
      bus.r_data       = mk(2'($urandom), ops[$urandom_range(0, 4)],
                            ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom));
      bus.rob_full     = ($urandom_range(0, 99) < 15);
      bus.rs_full_alu  = ($urandom_range(0, 3) == 0);
      bus.rs_full_br   = ($urandom_range(0, 3) == 0);
      bus.rs_full_lsu  = ($urandom_range(0, 3) == 0);
      bus.mispredict   = ($urandom_range(0, 99) < 5);
      bus.cdb_valid    = ($urandom_range(0, 1) == 1);
      bus.cdb_pd       = 7'($urandom);
    end
    cyc();
    idle();
    repeat (3) cyc();

    // Asynchronous reset while an LSU op is stalled.
    bus.rename_valid = 1'b1;
    bus.r_data = mk(2'b00, 7'h33, 7'd77);
    cyc();
    s_ins = mk(2'b10, 7'h03, 7'd9);
    bus.r_data      = s_ins;
    bus.rs_full_lsu = 1'b1;
    cyc();
    bus.rename_valid = 1'b0;
    @(negedge clk);
    check("arst_pre_rt77", bus.preg_rtable[77], 1'b0);
    check("arst_pre_hold", bus.d_data, s_ins);
    check("arst_pre_strobes", strobes(), 3'b000);
    @(posedge clk);
    #3;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("arst_d_data", bus.d_data, '0);
    check("arst_strobes", {strobes(), bus.rob_alloc}, 4'b0000);
    check("arst_rtable", bus.preg_rtable, {NUM_PREG{1'b1}});
    #2;
    idle();
    reset = 1'b1;
    #1;
    check("arst_release_ready", bus.dispatch_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

Dispatch stage sitting between rename and the three reservation stations (ALU, branch, LSU). It holds one renamed instruction per cycle, routes it to the reservation station selected by its `fu` field, and allocates its ROB entry in the same cycle. It owns the 128-entry physical-register ready table (`preg_rtable`) that every reservation station reads for wakeup: it clears a destination's bit on dispatch and sets bits from CDB writeback.

## Interface
- `NUM_PREG`, 128: physical registers; ready-table depth; preg index width is 7.
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-low.
- `reset`  in  1  asynchronous, active-low reset.
- `rename_valid`  in  1  rename presents `r_data`.
- `r_data`  in  `rename_data`  renamed instruction: pc, rob_tag, Opcode, func3, func7, fu, pd_new, ps1, ps2, imm.
- `dispatch_ready`  out  1  dispatch accepts `r_data` this cycle.
- `rob_full`  in  1  ROB cannot allocate.
- `rob_alloc`  out  1  ROB allocation strobe for `d_data.rob_tag`.
- `rs_full_alu`, `rs_full_br`, `rs_full_lsu`  in  1 each  reservation-station full flags.
- `di_en_alu`, `di_en_br`, `di_en_lsu`  out  1 each  write strobe into the selected station.
- `d_data`  out  `rename_data`  held instruction, shared by all stations.
- `cdb_valid`  in  1  writeback broadcast valid.
- `cdb_pd`  in  7  physical register written back.
- `mispredict`  in  1  flush request from ROB.
- `preg_rtable`  out  [0:127] x 1  ready bit per physical register.

## Operation
- `fu` encoding: 2'b00 ALU, 2'b01 branch, 2'b10 LSU. 2'b11 is treated as ALU.
- Single holding register `pend` (valid bit plus `rename_data`). `d_data` is `pend`.
- `go` = `pend.valid && !rob_full && !mispredict && !rs_full_<fu>`.
- `di_en_<fu>` = `go` for the matching station only; the other two are 0. `rob_alloc` = `go`.
- `dispatch_ready` = `!mispredict && (!pend.valid || go)`.
- Accept (`rename_valid && dispatch_ready`): at the clock edge, `pend` is loaded with `r_data` and valid is set to 1.
- If `go` with no accept, `pend.valid` is cleared.
- `pend` holds `pend` unchanged while stalled. There is no bypass, so an instruction always spends at least one cycle in `pend`.
- Destination write test `writes_rd`: Opcode is not 7'h23 (store) and not 7'h63 (branch), and `pd_new` is not 0.
- Ready table update, applied at the clock edge:
  - On `cdb_valid`, set bit `cdb_pd`.
  - On `go && writes_rd(pend)`, clear bit `pend.pd_new`.
  - If both updates hit the same index, the clear wins.
  - Bit 0 is forced to 1.
- Mispredict:
  - `pend.valid` is cleared, and there are no strobes that cycle.
  - The ready table is untouched. Squashed destinations return to the free list and are cleared again on reallocation.

## Timing
- Reset (`reset` low): `pend` is all zeros. All `preg_rtable` bits are 1. `d_data` = 0. `di_en_*`, `rob_alloc` = 0. `dispatch_ready` = 1 once `reset` is released.
- Reset asserted mid-stall discards `pend` immediately, without waiting for a clock edge.
- Latency: rename accept at edge N; `di_en_*` is high during cycle N+1 at the earliest. The reservation station captures the instruction at edge N+1.
- Throughput: 1 instruction/cycle while the target station and ROB are not full. Back-to-back accepts are allowed in the same cycle as `go`.
- Strobes are combinational from `pend` and the full flags. The full flags must be stable before the edge.
- A CDB set at edge N is visible on `preg_rtable` in cycle N+1.

## Test plan
- Reset, then 3 instructions with fu 00/01/10 on consecutive cycles, none full:
  - `di_en_alu`, `di_en_br`, `di_en_lsu` pulse in cycles 1, 2, 3.
  - `rob_alloc` is high all three cycles.
  - `dispatch_ready` stays 1.
- ALU op with pd_new=7'd40 and `rs_full_alu`=1 for 3 cycles:
  - `dispatch_ready`=0 and `di_en_alu`=0 for 3 cycles, and `d_data` is held.
  - After `rs_full_alu` drops: exactly one `di_en_alu` pulse, then `preg_rtable[40]`=0.
- `rob_full`=1 with `pend` valid: no strobes and `rob_alloc`=0. When `rob_full` drops, dispatch proceeds the next cycle.
- Same edge: dispatch clears pd=40 and CDB writes back 40 → `preg_rtable[40]`=0. CDB writes back 41 alone → bit 41 = 1 the next cycle.
- Store (7'h23) with pd_new=5: dispatches to LSU and `preg_rtable[5]` stays 1. An op with pd_new=0 leaves bit 0 at 1.
- `mispredict` while `pend` valid and stalled: `pend` is dropped, `dispatch_ready`=0 that cycle, and no `di_en_*` fires. Asserting `reset` low mid-stall clears all outputs asynchronously.
